// File: rtl/div_hilo_sequencer.sv
// Sequences one divide through the iterative Divider and writes remainder/quotient into HI/LO.
// Optional SIGNED_DIV_EN macro enables two's-complement operands (magnitude divide plus sign fix-up).
module div_hilo_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     div_q,
    output logic [WIDTH-1:0]     div_m,
    output logic                 div_rst_n,
    input  logic [2*WIDTH-1:0]   div_result,
    input  logic                 div_finish,
    output logic [WIDTH-1:0]     hi_out,
    output logic [WIDTH-1:0]     lo_out,
    output logic                 dbz,
    output logic                 tmo
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] load_m;
    logic [WIDTH-1:0] cap_hi;
    logic [WIDTH-1:0] cap_lo;
    logic [WIDTH-1:0] dbz_lo;

    assign rem  = div_result[2*WIDTH-1:WIDTH];
    assign quot = div_result[WIDTH-1:0];

`ifdef SIGNED_DIV_EN
    // Only the operand signs are needed after LOAD; the Divider holds the magnitudes.
    logic q_neg;
    logic r_neg;

    assign load_q = dividend[WIDTH-1] ? -dividend : dividend;
    assign load_m = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign cap_lo = q_neg ? -quot : quot;
    assign cap_hi = r_neg ? -rem  : rem;
    assign dbz_lo = dividend[WIDTH-1] ? WIDTH'(1) : '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
        end
    end
`else
    assign load_q = dividend;
    assign load_m = divisor;
    assign cap_lo = quot;
    assign cap_hi = rem;
    assign dbz_lo = '1;
`endif

    // Operands go to the Divider on the accepting edge so they are stable through LOAD
    // before div_rst_n releases it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_q     <= '0;
            div_m     <= '0;
            div_rst_n <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
            dbz       <= 1'b0;
            tmo       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    div_rst_n <= 1'b0;
                    if (start) begin
                        dbz <= 1'b0;
                        tmo <= 1'b0;
                        if (divisor == '0) begin
                            hi_out <= dividend;
                            lo_out <= dbz_lo;
                            dbz    <= 1'b1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            div_q <= load_q;
                            div_m <= load_m;
                            busy  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt       <= '0;
                    div_rst_n <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (div_finish) begin
                        div_rst_n <= 1'b0;
                        cnt       <= '0;
                        state     <= CAPTURE;
                    end else if (cnt == CNT_LAST) begin
                        div_rst_n <= 1'b0;
                        cnt       <= '0;
                        tmo       <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    hi_out <= cap_hi;
                    lo_out <= cap_lo;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// Directed bench for div_hilo_sequencer with a behavioural Divider whose finish latency is set per vector.
// Expected values follow SIGNED_DIV_EN when that macro is defined.
module tb_div_hilo_sequencer;

`ifdef SIGNED_DIV_EN
    localparam logic SGN = 1'b1;
`else
    localparam logic SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] div_q;
    logic [31:0] div_m;
    logic        div_rst_n;
    logic [63:0] div_result = '0;
    logic        div_finish = 1'b0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        dbz;
    logic        tmo;

    int   lat = 1;
    logic hang = 1'b0;
    int   mcnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_hilo_sequencer #(.WIDTH(32), .TIMEOUT_CYCLES(80)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_q(div_q), .div_m(div_m), .div_rst_n(div_rst_n),
        .div_result(div_result), .div_finish(div_finish),
        .hi_out(hi_out), .lo_out(lo_out), .dbz(dbz), .tmo(tmo)
    );

    // Divider stand-in: counts cycles out of reset and raises finish after 'lat' of them.
    always @(negedge clk) begin
        if (!div_rst_n) begin
            mcnt = 0;
            div_finish = 1'b0;
        end else if (!hang) begin
            mcnt++;
            if (mcnt >= lat && div_m != 0) begin
                div_finish = 1'b1;
                div_result = {div_q % div_m, div_q / div_m};
            end
        end
    end

    typedef struct {
        logic [31:0] dividend;
        logic [31:0] divisor;
        int          lat;
        logic        hang;
        int          poke_busy;
        logic        poke_done;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        logic        exp_tmo;
        int          exp_cycles;
    } vec_t;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the DONE cycle (FSM back in IDLE).
    task automatic apply_stimulus(input vec_t v, input string tag);
        int   k;
        logic ok_busy;
        logic saw_rst;
        start    = 1'b1;
        dividend = v.dividend;
        divisor  = v.divisor;
        lat      = v.lat;
        hang     = v.hang;
        @(negedge clk);
        k       = 1;
        ok_busy = 1'b1;
        saw_rst = 1'b0;
        while (done !== 1'b1 && k < 300) begin
            start = (k == v.poke_busy);
            if (start) begin
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            if (busy !== (v.divisor != 0)) ok_busy = 1'b0;
            if (div_rst_n === 1'b1) saw_rst = 1'b1;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check_output({tag, " latency"}, k, v.exp_cycles);
        check_output({tag, " hi"}, hi_out, v.exp_hi);
        check_output({tag, " lo"}, lo_out, v.exp_lo);
        check_output({tag, " dbz"}, dbz, v.exp_dbz);
        check_output({tag, " tmo"}, tmo, v.exp_tmo);
        check_output({tag, " busy during op"}, ok_busy, 1'b1);
        check_output({tag, " busy in done"}, busy, 1'b0);
        check_output({tag, " div_rst_n in done"}, div_rst_n, 1'b0);
        check_output({tag, " divider released"}, saw_rst, v.divisor != 0);
        if (v.poke_done) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd9;
        end
        @(negedge clk);
        start = 1'b0;
        check_output({tag, " single done pulse"}, done, 1'b0);
        check_output({tag, " busy after done"}, busy, 1'b0);
    endtask

    vec_t vecs[11];
    vec_t rv;

    initial begin
        vecs[0]  = '{32'd10, 32'd3, 5, 1'b0, 3, 1'b0, 32'd1, 32'd3, 1'b0, 1'b0, 8};
        vecs[1]  = '{32'd30480, 32'd11, 34, 1'b0, 0, 1'b0, 32'd10, 32'd2770, 1'b0, 1'b0, 37};
        vecs[2]  = '{32'd68, 32'd2, 1, 1'b0, 0, 1'b1, 32'd0, 32'd34, 1'b0, 1'b0, 4};
        vecs[3]  = '{32'd1, 32'hFFFFFFFF, 3, 1'b0, 0, 1'b0,
                     SGN ? 32'd0 : 32'd1, SGN ? 32'hFFFFFFFF : 32'd0, 1'b0, 1'b0, 6};
        vecs[4]  = '{32'hFFFFFFF9, 32'd2, 6, 1'b0, 0, 1'b0,
                     SGN ? 32'hFFFFFFFF : 32'd1, SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC, 1'b0, 1'b0, 9};
        vecs[5]  = '{32'h80000000, 32'h10, 2, 1'b0, 0, 1'b0,
                     32'd0, SGN ? 32'hF8000000 : 32'h08000000, 1'b0, 1'b0, 5};
        vecs[6]  = '{32'd100, 32'd7, 80, 1'b0, 0, 1'b0, 32'd2, 32'd14, 1'b0, 1'b0, 83};
        vecs[7]  = '{32'd97, 32'd0, 1, 1'b0, 0, 1'b0, 32'd97, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
        vecs[8]  = '{32'd5, 32'd5, 1, 1'b1, 0, 1'b0, 32'd97, 32'hFFFFFFFF, 1'b0, 1'b1, 82};
        vecs[9]  = '{32'd12, 32'd4, 2, 1'b0, 0, 1'b0, 32'd0, 32'd3, 1'b0, 1'b0, 5};
        vecs[10] = '{32'hFFFFFFFC, 32'd0, 1, 1'b0, 0, 1'b0,
                     32'hFFFFFFFC, SGN ? 32'd1 : 32'hFFFFFFFF, 1'b1, 1'b0, 1};

        repeat (2) @(negedge clk);
        check_output("reset hi", hi_out, 32'd0);
        check_output("reset lo", lo_out, 32'd0);
        check_output("reset div_q/div_m", {div_q, div_m}, 64'd0);
        check_output("reset flags", {busy, done, div_rst_n, dbz, tmo}, 5'd0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort an operation mid-RUN with reset, then confirm a fresh one completes.
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        hang     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_output("pre-reset in run", {busy, div_rst_n}, 2'b11);
        reset = 1'b0;
        #1;
        check_output("mid-run reset hi/lo", {hi_out, lo_out}, 64'd0);
        check_output("mid-run reset div_q/div_m", {div_q, div_m}, 64'd0);
        check_output("mid-run reset flags", {busy, done, div_rst_n, dbz, tmo}, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        rv = '{32'd80, 32'd1, 4, 1'b0, 0, 1'b0, 32'd0, 32'd80, 1'b0, 1'b0, 7};
        apply_stimulus(rv, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
